data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words in the internal data array (power of two, at least 4).
REQ-002 Parameter WAIT_CYCLES, default 2: extra wait states before every response (0..15).
REQ-003 Port clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port req_valid  in  1  core presents a load or store request.
REQ-006 Port req_ready  out  1  responder accepts a request this cycle.
REQ-007 Port req_we  in  1  1 = store, 0 = load.
REQ-008 Port req_addr  in  32  byte address, taken from the core ALU result.
REQ-009 Port req_wdata  in  32  store data, taken from register-file rs2.
REQ-010 Port req_funct3  in  3  RV32I size/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011 Port resp_valid  out  1  response available.
REQ-012 Port resp_ready  in  1  core consumes the response.
REQ-013 Port resp_rdata  out  32  load data, sign- or zero-extended; 0 for stores and errors.
REQ-014 Port resp_err  out  1  access was misaligned, out of range, or used an illegal funct3.

Function
REQ-015 A request SHALL be accepted only in a cycle where req_valid and req_ready are both 1; req_addr, req_we, req_wdata and req_funct3 SHALL be captured in that cycle.
REQ-016 FSM states SHALL be IDLE, WAIT and RESP.
- IDLE: req_ready = 1. On accept, go to WAIT if WAIT_CYCLES > 0, otherwise go to RESP.
- WAIT: a counter loads WAIT_CYCLES-1 on accept and decrements each cycle; go to RESP when the counter is 0.
- RESP: resp_valid = 1; go to IDLE when resp_ready = 1.
REQ-017 req_ready SHALL be 0 in WAIT and RESP; a request held through those states is not accepted until IDLE.
REQ-018 Accept-to-resp_valid latency SHALL be exactly WAIT_CYCLES+1 cycles.
REQ-019 The word index SHALL be addr[log2(DEPTH_WORDS)+1:2]. Any addr bit above the array range that is set SHALL be an out-of-range error.
REQ-020 Alignment: halfword accesses require addr[0] = 0; word accesses require addr[1:0] = 00. Any other alignment is a misaligned error.
REQ-021 A store SHALL update the array only in the cycle of entry to RESP, only the addressed bytes (byte-lane enables from addr[1:0] and size), and only when no error is flagged.
REQ-022 A load SHALL read the array on entry to RESP and register the result. Byte/halfword data is selected by addr[1:0]. funct3 000/001 sign-extend; 100/101 zero-extend.
REQ-023 resp_rdata and resp_err SHALL hold stable while resp_valid = 1 and resp_ready = 0.
REQ-024 When an error is flagged, resp_err = 1, resp_rdata = 0, and the array is unchanged.
REQ-025 A load from the same address immediately after a store SHALL return the stored data; there is no stale data.

Reset
REQ-026 With reset = 0 at a clock edge: state SHALL become IDLE, the wait counter 0, resp_valid 0, resp_rdata 0 and resp_err 0; req_ready SHALL be 1 in the first cycle after reset is released.
REQ-027 Reset during WAIT or RESP SHALL abort the transaction; a pending store SHALL NOT be written.
REQ-028 Array contents SHALL NOT be cleared by reset.

Structure
REQ-029 A shared package SHALL hold the funct3 size encodings (LB, LH, LW, LBU, LHU; SB, SH, SW) and the FSM state enum.
REQ-030 Byte-lane enable generation and load extraction/extension SHALL be one combinational sub-module, mem_lane_align, reusable by the instruction-fetch side.

Verification
REQ-031 Store word 0xDEADBEEF at addr 0x10, then load word from 0x10 -> rdata 0xDEADBEEF, err 0, resp_valid exactly 3 cycles after accept (WAIT_CYCLES = 2).
REQ-032 Store byte 0x80 at 0x13 over 0x00000000, then lb 0x13 -> 0xFFFFFF80, lbu 0x13 -> 0x00000080, lw 0x10 -> 0x80000000.
REQ-033 sh to 0x11 and lw from 0x12 -> err 1, rdata 0, and a later lw 0x10 returns the unchanged word.
REQ-034 lw from 0x00000400 with DEPTH_WORDS = 256 -> err 1.
REQ-035 Hold resp_ready = 0 for 5 cycles -> resp_valid and rdata stable, req_ready 0 throughout; then back-to-back requests with resp_ready = 1 -> one accept every WAIT_CYCLES+2 cycles.
REQ-036 Assert reset = 0 mid-WAIT on a store to 0x20 -> outputs reach reset values, and lw 0x20 afterwards returns the old contents.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg
// Shared definitions for the data-memory responder and its lane-alignment helper:
// the RV32I funct3 load/store size encodings and the responder FSM state type.
// No ports (package).
package data_mem_responder_pkg;

    // Load size/sign encodings (funct3).
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store size encodings (funct3); share values with the signed loads.
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// mem_lane_align
// Combinational byte-lane helper shared by the data and instruction-fetch sides.
// Produces store byte enables and lane-replicated store data, extracts and
// sign/zero-extends load data from a full 32-bit word, and flags misaligned
// addresses and funct3 codes that are illegal for the access direction.
// Ports:
//   we          in   1 = store, 0 = load
//   funct3      in   RV32I size/sign code
//   addr_lo     in   byte offset within the word (addr[1:0])
//   wdata       in   store data, right-justified
//   rdata_word  in   full word read from the array
//   byte_en     out  store byte-lane enables (meaningful only without error)
//   wdata_lanes out  store data replicated onto every lane of its size
//   load_data   out  extracted and extended load data
//   misaligned  out  address offset not legal for the access size
//   illegal     out  funct3 not legal for this access direction
module mem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lanes,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [31:0] shifted;

    // The addressed byte/halfword is shifted down to bit 0; funct3[2] marks
    // the unsigned load variants, which are not legal as stores.
    always_comb begin
        shifted     = rdata_word >> {addr_lo, 3'b000};
        byte_en     = 4'b0000;
        wdata_lanes = wdata;
        load_data   = 32'd0;
        misaligned  = 1'b0;
        illegal     = 1'b0;
        case (funct3)
            LB, LBU: begin
                illegal     = we && funct3[2];
                byte_en     = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                load_data   = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
            end
            LH, LHU: begin
                illegal     = we && funct3[2];
                misaligned  = addr_lo[0];
                byte_en     = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lanes = {2{wdata[15:0]}};
                load_data   = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
            end
            LW: begin
                misaligned  = (addr_lo != 2'b00);
                byte_en     = 4'b1111;
                load_data   = rdata_word;
            end
            default: begin
                illegal     = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Data-memory responder for a simple RV32I core: accepts one load/store request
// at a time, waits WAIT_CYCLES states, then accesses an internal word array and
// presents a registered response until the core consumes it.
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  request accepted this cycle (IDLE only)
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   req_funct3  in   size/sign code
//   resp_valid  out  response available
//   resp_ready  in   response consumed
//   resp_rdata  out  load data (0 for stores and errors)
//   resp_err    out  misaligned, out-of-range or illegal funct3
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W       = $clog2(DEPTH_WORDS);
    localparam int         WAIT_LOAD_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_LOAD_I);

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [2:0]  cap_funct3;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_funct3;
    logic [IDX_W-1:0] idx;
    logic [31:0] mem_word;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lanes;
    logic [31:0] load_data;
    logic        misaligned;
    logic        illegal;
    logic        out_of_range;
    logic        access_err;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With zero wait states the array access happens on the accept edge itself,
    // so the live request is used while still in IDLE; otherwise the captured copy.
    assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (wait_cnt == 4'd0));
    assign cur_we     = (state == IDLE) ? req_we     : cap_we;
    assign cur_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;

    assign idx          = cur_addr[IDX_W+1:2];
    assign out_of_range = (cur_addr >> (IDX_W + 2)) != 32'd0;
    assign mem_word     = mem[idx];
    assign access_err   = misaligned || illegal || out_of_range;

    mem_lane_align u_lane_align (
        .we          (cur_we),
        .funct3      (cur_funct3),
        .addr_lo     (cur_addr[1:0]),
        .wdata       (cur_wdata),
        .rdata_word  (mem_word),
        .byte_en     (byte_en),
        .wdata_lanes (wdata_lanes),
        .load_data   (load_data),
        .misaligned  (misaligned),
        .illegal     (illegal)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wait_cnt   <= 4'd0;
            cap_we     <= 1'b0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            cap_funct3 <= 3'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_we     <= req_we;
                        cap_addr   <= req_addr;
                        cap_wdata  <= req_wdata;
                        cap_funct3 <= req_funct3;
                        wait_cnt   <= WAIT_LOAD;
                        state      <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // Response registers only change on entry to RESP, so they hold
            // for as long as the core stalls the response.
            if (enter_resp) begin
                resp_err   <= access_err;
                resp_rdata <= (access_err || cur_we) ? 32'd0 : load_data;
            end
        end
    end

    // The array has no reset; a store lands only on entry to RESP and only when
    // error-free, so an aborted or faulting store leaves contents untouched.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Scoreboard bench for data_mem_responder: directed requests push their
// hand-computed responses into a queue; a negedge monitor pops and compares
// each response, and also checks latency and output stability while stalled.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int DEPTH_WORDS = 256;
    localparam int WAIT_CYCLES = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int tests = 0;
    int failures = 0;
    int cycle = 0;

    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [31:0] prev_rdata = 32'd0;
    logic        prev_err = 1'b0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well away from both edges.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_stimulus(input string name, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  input logic [31:0] exp_rdata, input logic exp_err,
                                  input bit keep_valid, output int acc);
        int   waited;
        exp_t e;
        waited     = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        acc = cycle;
        if (!req_ready) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: request not accepted within 50 cycles, required acceptance", name);
            req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.acc   = cycle;
        exp_q.push_back(e);
        tick();
        if (!keep_valid) req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 100) begin
            tick();
            w++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL %s: %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: latency on each new response, stability while stalled,
    // req_ready low while busy, and data/err on each handshake.
    always @(negedge clk) begin
        if (reset && resp_valid) begin
            if (!prev_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid=1, required no response");
                end else begin
                    check_output("latency", 32'(cycle - exp_q[0].acc), 32'(WAIT_CYCLES + 1));
                end
            end else if (!prev_hs) begin
                check_output("hold_rdata", resp_rdata, prev_rdata);
                check_output("hold_err", {31'd0, resp_err}, {31'd0, prev_err});
            end
            check_output("req_ready_busy", {31'd0, req_ready}, 32'd0);
            if (resp_ready && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_output("resp_rdata", resp_rdata, mon_e.rdata);
                check_output("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
            end
        end
        prev_valid = reset && resp_valid;
        prev_hs    = resp_valid && resp_ready;
        prev_rdata = resp_rdata;
        prev_err   = resp_err;
    end

    initial begin
        int a0, a1, a2, w;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'd0;
        resp_ready = 1'b1;
        repeat (3) tick();
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_resp_err", {31'd0, resp_err}, 32'd0);
        reset = 1'b1;
        tick();

        // Word store/load round trip.
        apply_stimulus("sw_10", 1'b1, 32'h10, 32'hDEADBEEF, SW, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("lw_10", 1'b0, 32'h10, 32'h0, LW, 32'hDEADBEEF, 1'b0, 1'b0, a0);

        // Byte store into the top lane, then signed/unsigned/word reads.
        apply_stimulus("sw_10_clr", 1'b1, 32'h10, 32'h0, SW, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("sb_13", 1'b1, 32'h13, 32'h80, SB, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("lb_13", 1'b0, 32'h13, 32'h0, LB, 32'hFFFFFF80, 1'b0, 1'b0, a0);
        apply_stimulus("lbu_13", 1'b0, 32'h13, 32'h0, LBU, 32'h00000080, 1'b0, 1'b0, a0);
        apply_stimulus("lw_10b", 1'b0, 32'h10, 32'h0, LW, 32'h80000000, 1'b0, 1'b0, a0);

        // Misaligned accesses flag errors and leave the array untouched.
        apply_stimulus("sh_11", 1'b1, 32'h11, 32'hFFFF, SH, 32'h0, 1'b1, 1'b0, a0);
        apply_stimulus("lw_12", 1'b0, 32'h12, 32'h0, LW, 32'h0, 1'b1, 1'b0, a0);
        apply_stimulus("lw_10c", 1'b0, 32'h10, 32'h0, LW, 32'h80000000, 1'b0, 1'b0, a0);

        // Halfword lanes, sign handling and illegal funct3 codes.
        apply_stimulus("sw_14", 1'b1, 32'h14, 32'h11223344, SW, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("sh_16", 1'b1, 32'h16, 32'h0000ABCD, SH, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("lh_16", 1'b0, 32'h16, 32'h0, LH, 32'hFFFFABCD, 1'b0, 1'b0, a0);
        apply_stimulus("lhu_16", 1'b0, 32'h16, 32'h0, LHU, 32'h0000ABCD, 1'b0, 1'b0, a0);
        apply_stimulus("lb_15", 1'b0, 32'h15, 32'h0, LB, 32'h00000033, 1'b0, 1'b0, a0);
        apply_stimulus("ld_f3_011", 1'b0, 32'h14, 32'h0, 3'b011, 32'h0, 1'b1, 1'b0, a0);
        apply_stimulus("st_f3_100", 1'b1, 32'h14, 32'hFF, 3'b100, 32'h0, 1'b1, 1'b0, a0);
        apply_stimulus("lw_14", 1'b0, 32'h14, 32'h0, LW, 32'hABCD3344, 1'b0, 1'b0, a0);

        // Range boundary: last word is fine, first word beyond is an error.
        apply_stimulus("sw_3fc", 1'b1, 32'h3FC, 32'h5A5A5A5A, SW, 32'h0, 1'b0, 1'b0, a0);
        apply_stimulus("lw_3fc", 1'b0, 32'h3FC, 32'h0, LW, 32'h5A5A5A5A, 1'b0, 1'b0, a0);
        apply_stimulus("lw_400", 1'b0, 32'h400, 32'h0, LW, 32'h0, 1'b1, 1'b0, a0);

        // Stalled response: monitor checks hold values every cycle.
        apply_stimulus("sw_20", 1'b1, 32'h20, 32'h12345678, SW, 32'h0, 1'b0, 1'b0, a0);
        drain("drain_pre_hold");
        resp_ready = 1'b0;
        apply_stimulus("lw_20_hold", 1'b0, 32'h20, 32'h0, LW, 32'h12345678, 1'b0, 1'b0, a0);
        w = 0;
        while (!resp_valid && w < 20) begin
            tick();
            w++;
        end
        check_output("hold_resp_seen", {31'd0, resp_valid}, 32'd1);
        repeat (5) tick();
        resp_ready = 1'b1;
        drain("drain_hold");

        // Back-to-back requests with req_valid held high.
        apply_stimulus("b2b_0", 1'b0, 32'h10, 32'h0, LW, 32'h80000000, 1'b0, 1'b1, a0);
        apply_stimulus("b2b_1", 1'b0, 32'h14, 32'h0, LW, 32'hABCD3344, 1'b0, 1'b1, a1);
        apply_stimulus("b2b_2", 1'b0, 32'h20, 32'h0, LW, 32'h12345678, 1'b0, 1'b0, a2);
        check_output("b2b_gap_01", 32'(a1 - a0), 32'(WAIT_CYCLES + 2));
        check_output("b2b_gap_12", 32'(a2 - a1), 32'(WAIT_CYCLES + 2));
        drain("drain_b2b");
        tick();

        // Reset in the middle of WAIT aborts a store to 0x20.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h20;
        req_wdata  = 32'hCAFEF00D;
        req_funct3 = SW;
        w = 0;
        while (!req_ready && w < 50) begin
            tick();
            w++;
        end
        check_output("abort_accept", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        reset     = 1'b0;
        tick();
        check_output("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("abort_resp_rdata", resp_rdata, 32'd0);
        check_output("abort_resp_err", {31'd0, resp_err}, 32'd0);
        check_output("abort_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check_output("release_req_ready", {31'd0, req_ready}, 32'd1);
        apply_stimulus("lw_20_after_abort", 1'b0, 32'h20, 32'h0, LW, 32'h12345678, 1'b0, 1'b0, a0);
        drain("drain_final");
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
